// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the sequential multiply/divide unit
package muldiv_pkg;

  // Operation encoding as presented on the op input
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // One radix-2 step per cycle over 32-bit magnitudes
  localparam int ITER = 32;

  function automatic logic op_is_div(op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - iterative radix-2 shift-add multiplier / restoring divider on magnitudes
module muldiv_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // hi holds the partial product upper half (mult) or the running remainder (div);
  // lo holds the multiplier being shifted out (mult) or the dividend/quotient (div).
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] m_q, m_d;

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;
    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : 33'd0);
    rem_sh = {hi_q, lo_q[31]};
    diff   = {1'b0, rem_sh} - {2'b00, m_q};
    if (load_i) begin
      hi_d = 32'd0;
      lo_d = a_i;
      m_d  = b_i;
    end else if (step_i) begin
      if (div_i) begin
        // A non-negative trial difference is always below the divisor, so it fits in 32 bits
        if (!diff[33]) begin
          hi_d = diff[31:0];
          lo_d = {lo_q[30:0], 1'b1};
        end else begin
          hi_d = rem_sh[31:0];
          lo_d = {lo_q[30:0], 1'b0};
        end
      end else begin
        hi_d = sum[32:1];
        lo_d = {sum[0], lo_q[31:1]};
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
      m_q  <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      m_q  <= m_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential MULT/MULTU/DIV/DIVU unit with HI/LO write strobe
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  op_e         op_q;
  logic        neg_q;      // negate product (mult) or quotient (div)
  logic        neg_rem_q;  // negate remainder: dividend was negative
  logic        dz_q;       // current DONE is a divide-by-zero report, not a result

  op_e         op_in;
  logic        accept;
  logic        in_signed;
  logic        in_dz;
  logic [31:0] a_mag, b_mag;
  logic        dp_load, dp_step;
  logic [31:0] dp_hi, dp_lo;
  logic [63:0] prod;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_dz     = op_is_div(op_in) && (b == 32'd0);
  assign a_mag     = (in_signed && a[31]) ? -a : a;
  assign b_mag     = (in_signed && b[31]) ? -b : b;

  // Next-state, iteration counter and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          accept = 1'b1;
          cnt_d  = 6'd0;
          if (in_dz) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            dp_load = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          dp_step = 1'b1;
          if (cnt_q == 6'(ITER - 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and latched operation attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q      <= op_in;
        neg_q     <= in_signed && (a[31] ^ b[31]);
        neg_rem_q <= in_signed && a[31];
        dz_q      <= in_dz;
      end
    end
  end

  muldiv_datapath u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load_i (dp_load),
    .step_i (dp_step),
    .div_i  (op_is_div(op_q)),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (dp_hi),
    .lo_o   (dp_lo)
  );

  assign busy        = (state_q != S_IDLE);
  assign hilo_we     = (state_q == S_DONE) && !dz_q && !cancel && !rst;
  assign div_by_zero = (state_q == S_DONE) && dz_q;

  // Sign correction of the magnitude result; outputs held at zero outside the write strobe
  always_comb begin
    hi_o = 32'd0;
    lo_o = 32'd0;
    prod = {dp_hi, dp_lo};
    if (neg_q) begin
      prod = -prod;
    end
    if (hilo_we) begin
      if (op_is_div(op_q)) begin
        lo_o = neg_q ? -dp_lo : dp_lo;
        hi_o = neg_rem_q ? -dp_hi : dp_hi;
      end else begin
        hi_o = prod[63:32];
        lo_o = prod[31:0];
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq against an arithmetic reference model
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy, hilo_we, div_by_zero;
  logic [31:0] hi_o, lo_o;

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .cancel      (cancel),
    .busy        (busy),
    .hilo_we     (hilo_we),
    .hi_o        (hi_o),
    .lo_o        (lo_o),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  flags;  // {hilo_we, div_by_zero} expected at cyc
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic, returns {hi, lo}
  function automatic logic [63:0] ref_model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = 64'(sx * sy); end
      2'b01: begin p = {32'd0, x} * {32'd0, y}; end
      2'b10: begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      default: begin p = {x % y, x / y}; end
    endcase
    return p;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one accepted start in the current cycle k and record what must follow
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic dz, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    int k;
    k = cyc;
    start = 1'b1; op = o; a = x; b = y;
    e.flags = dz ? 2'b01 : 2'b10;
    e.hi    = dz ? 32'd0 : eh;
    e.lo    = dz ? 32'd0 : el;
    e.cyc   = dz ? k + 1 : k + 33;
    sb.push_back(e);
    busy_lo = k + 1;
    busy_hi = e.cyc;
    tick(1);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // While busy, wiggle inputs (including stray starts) that must all be ignored
  task automatic noisy_wait(input int n);
    repeat (n) begin
      start = ($urandom_range(0, 5) == 0);
      op = 2'($urandom); a = $urandom; b = $urandom;
      tick(1);
    end
    start = 1'b0;
  endtask

  task automatic drop_inflight(input int c);
    busy_hi = c;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
  endtask

  task automatic directed(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el);
    issue(o, x, y, 1'b0, eh, el);
    noisy_wait(33);
  endtask

  // Monitor: compares every DUT cycle against the busy window and the scoreboard head
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      logic exp_busy;
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_result cyc=%0d got=none exp_cyc=%0d", cyc, sb[0].cyc);
        sb.delete(0);
      end
      if (hilo_we || div_by_zero) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got we=%b dz=%b exp=none", cyc, hilo_we, div_by_zero);
        end else begin
          e = sb.pop_front();
          if ({hilo_we, div_by_zero} !== e.flags || cyc != e.cyc ||
              hi_o !== e.hi || lo_o !== e.lo) begin
            errors++;
            $display("FAIL result cyc=%0d got we/dz=%b hi=%h lo=%h exp cyc=%0d we/dz=%b hi=%h lo=%h",
                     cyc, {hilo_we, div_by_zero}, hi_o, lo_o, e.cyc, e.flags, e.hi, e.lo);
          end
        end
      end else begin
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
          errors++;
          $display("FAIL hold_zero cyc=%0d got hi=%h lo=%h exp=0", cyc, hi_o, lo_o);
        end
      end
    end
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] r;
    logic        rdz;
    int          k;

    rst = 1'b1;
    tick(2);
    chk_en = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);

    directed(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    directed(2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    directed(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    directed(2'b11, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC);
    directed(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    directed(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

    // Divide by zero, both flavours
    issue(2'b11, 32'd5, 32'd0, 1'b1, 32'd0, 32'd0);
    noisy_wait(1);
    tick(1);
    issue(2'b10, 32'h80000000, 32'd0, 1'b1, 32'd0, 32'd0);
    noisy_wait(1);
    tick(1);

    // Cancel at k+10, new start at k+11 completes at k+44
    issue(2'b01, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0, 32'd0);
    k = cyc - 1;
    tick(9);
    cancel = 1'b1;
    drop_inflight(k + 10);
    tick(1);
    cancel = 1'b0;
    r = ref_model(2'b00, 32'hDEADBEEF, 32'h00000123);
    issue(2'b00, 32'hDEADBEEF, 32'h00000123, 1'b0, r[63:32], r[31:0]);
    noisy_wait(33);

    // Cancel while idle suppresses a same-cycle start
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    tick(1);
    start = 1'b0; cancel = 1'b0;
    tick(3);

    // Second start at k+5 with other operands is ignored
    issue(2'b01, 32'd1000, 32'd3000, 1'b0, 32'd0, 32'd3000000);
    tick(4);
    start = 1'b1; op = 2'b11; a = 32'd77; b = 32'd0;
    tick(1);
    start = 1'b0;
    tick(28);

    // Reset at k+20 abandons the operation
    issue(2'b10, 32'h7FFFFFFF, 32'd3, 1'b0, 32'd1, 32'h2AAAAAAA);
    k = cyc - 1;
    tick(19);
    rst = 1'b1; start = 1'b1; cancel = 1'b1;
    drop_inflight(k + 20);
    tick(1);
    rst = 1'b0; start = 1'b0; cancel = 1'b0;
    tick(2);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      rdz = ro[1] && (rb == 32'd0);
      r = rdz ? 64'd0 : ref_model(ro, ra, rb);
      issue(ro, ra, rb, rdz, r[63:32], r[31:0]);
      noisy_wait(rdz ? 1 : 33);
      tick($urandom_range(0, 2));
    end

    tick(3);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
